// File: rtl/spis_pkg.sv
// -----------------------------------------------------------------------------
// spis_pkg
// Shared types and constants for the two-port memory arbiter.
//   state_e           : arbiter FSM states (IDLE, ACCESS, WAIT, DONE)
//   SPIS_ADDR_WIDTH   : default memory address width (12)
//   SPIS_DATA_WIDTH   : default memory data width (8)
//   PORT_CPU/PORT_DMA : port indices as stored in the owner register
// -----------------------------------------------------------------------------
package spis_pkg;

  localparam int SPIS_ADDR_WIDTH = 12;
  localparam int SPIS_DATA_WIDTH = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // With only two ports the "other" requester is simply the inverted index.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/spis_rr_pick.sv
// -----------------------------------------------------------------------------
// spis_rr_pick
// Combinational winner select for the IDLE arbitration point.
//   req0, req1 : in  - per-port request
//   last_owner : in  - port that owned the most recent access
//   any_req    : out - at least one port is requesting
//   winner     : out - index of the winning port (valid when any_req)
// Build option SPIS_ARB_FIXED_PRIORITY_EN: port 0 always wins a conflict and
// last_owner is ignored. Default build: round-robin, the port that did not
// own the last access wins a conflict.
// -----------------------------------------------------------------------------
module spis_rr_pick
  import spis_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic any_req,
  output logic winner
);

`ifdef SPIS_ARB_FIXED_PRIORITY_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    any_req = req0 | req1;
    winner  = req0 ? PORT_CPU : PORT_DMA;
  end
`else
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = other_port(last_owner);
    end else begin
      winner = req0 ? PORT_CPU : PORT_DMA;
    end
  end
`endif

endmodule

// File: rtl/spis_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spis_bus_arbiter
// Shares one memory between port 0 (CPU) and port 1 (DMA/debug loader) with a
// req/grant/done handshake, round-robin arbitration and a bounded lock for
// multi-byte bursts.
// Ports:
//   clock, resetN            : clock (rising edge), async active-low reset
//   req*/we*/lock*           : per-port request, write enable, burst lock
//   addr*/wdata*             : per-port address and write data
//   grant0/grant1            : one-hot-or-zero ownership
//   done0/done1              : one-cycle completion pulse
//   rdata                    : read data, valid with the done pulse
//   memAddress/memWriteData  : registered memory address / write data
//   memWrite                 : write strobe, high in the ACCESS cycle only
//   memReadData              : memory read data
// Build option SPIS_ARB_FIXED_PRIORITY_EN: port 0 wins every conflict and its
// locked bursts are unbounded; MAX_BURST then only limits port 1.
// Timing: the done pulse and rdata are registered off the DONE state, so a
// single access completes MEM_LATENCY+2 cycles after the request is sampled,
// and each further locked access takes MEM_LATENCY+1 cycles.
// -----------------------------------------------------------------------------
module spis_bus_arbiter
  import spis_pkg::*;
#(
  parameter int ADDR_WIDTH  = SPIS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SPIS_DATA_WIDTH,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memWrite,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  localparam logic [3:0] LAT_LOAD  = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST - 1);
  localparam logic [3:0] BURST_SAT = 4'hF;

  // State and registered outputs.
  state_e                state_q, state_d;
  logic                  last_owner_q, last_owner_d;  // also the current owner
  logic [3:0]            burst_q, burst_d;
  logic [3:0]            lat_q, lat_d;
  logic                  we_q, we_d;
  logic                  grant0_q, grant0_d;
  logic                  grant1_q, grant1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Arbitration and burst decision terms.
  logic pick_any, pick_winner;
  logic start_en, start_port;
  logic own_req, own_lock, other_req;
  logic own_burst, burst_at_cap, owner_bounded;

  spis_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .any_req    (pick_any),
    .winner     (pick_winner)
  );

`ifdef SPIS_ARB_FIXED_PRIORITY_EN
  // CPU bursts are never cut; only DMA bursts count against MAX_BURST.
  assign owner_bounded = (last_owner_q == PORT_DMA);
`else
  assign owner_bounded = 1'b1;
`endif

  assign own_req      = (last_owner_q == PORT_DMA) ? req1  : req0;
  assign own_lock     = (last_owner_q == PORT_DMA) ? lock1 : lock0;
  assign other_req    = (last_owner_q == PORT_DMA) ? req0  : req1;
  assign own_burst    = own_req & own_lock;   // lock without req is ignored
  assign burst_at_cap = (burst_q >= BURST_CAP);

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // variable unassigned; that is what keeps this block free of latches.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    lat_d        = lat_q;
    we_d         = we_q;
    grant0_d     = grant0_q;
    grant1_d     = grant1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    start_en     = 1'b0;
    start_port   = pick_winner;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          start_en   = 1'b1;
          start_port = pick_winner;
          burst_d    = 4'd0;
        end
      end

      ACCESS: begin
        lat_d   = LAT_LOAD;
        state_d = (MEM_LATENCY == 1) ? DONE : WAIT;
      end

      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (last_owner_q == PORT_DMA) begin
          done1_d = 1'b1;
        end else begin
          done0_d = 1'b1;
        end
        if (!we_q) begin
          rdata_d = memReadData;
        end

        if (own_burst && !(other_req && burst_at_cap && owner_bounded)) begin
          // Locked continuation: keep the grant, relatch the owner's request.
          start_en   = 1'b1;
          start_port = last_owner_q;
          burst_d    = (burst_q == BURST_SAT) ? burst_q : burst_q + 4'd1;
        end else if (own_burst && other_req) begin
          // Burst limit hit with the other port waiting: hand over directly.
          start_en   = 1'b1;
          start_port = other_port(last_owner_q);
          burst_d    = 4'd0;
        end else begin
          state_d  = IDLE;
          grant0_d = 1'b0;
          grant1_d = 1'b0;
          burst_d  = 4'd0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Common access launch: latch the winner's request into the mem registers.
    if (start_en) begin
      state_d      = ACCESS;
      last_owner_d = start_port;
      grant0_d     = (start_port == PORT_CPU);
      grant1_d     = (start_port == PORT_DMA);
      we_d         = (start_port == PORT_DMA) ? we1    : we0;
      mem_addr_d   = (start_port == PORT_DMA) ? addr1  : addr0;
      mem_wdata_d  = (start_port == PORT_DMA) ? wdata1 : wdata0;
      mem_write_d  = we_d;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      last_owner_q <= PORT_DMA;  // port 0 wins the first conflict
      burst_q      <= 4'd0;
      lat_q        <= 4'd0;
      we_q         <= 1'b0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      lat_q        <= lat_d;
      we_q         <= we_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign grant0       = grant0_q;
  assign grant1       = grant1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata        = rdata_q;
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign memWrite     = mem_write_q;

endmodule

// File: tb/tb_spis_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spis_bus_arbiter
// Two arbiter instances: u_dut (MEM_LATENCY=1, MAX_BURST=4) with a scoreboard
// monitor, and u_dut_a (MEM_LATENCY=15) for reset abort and long latency.
// Each instance has its own behavioural memory.
// -----------------------------------------------------------------------------
module tb_spis_bus_arbiter;
  import spis_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int LAT_A = 15;

  typedef struct {
    logic          is_wr;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- main instance ----------------
  logic          resetN;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          grant0, grant1, done0, done1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem [0:4095];

  spis_bus_arbiter #(.MEM_LATENCY(1), .MAX_BURST(4)) u_dut (
    .clock(clock), .resetN(resetN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .rdata(rdata), .memAddress(mem_address), .memWriteData(mem_wdata),
    .memWrite(mem_write), .memReadData(mem_rdata)
  );

  always @(posedge clock) begin
    if (mem_write) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
  end

  // ---------------- long-latency instance ----------------
  logic          resetN_a;
  logic          req0_a, req1_a, we0_a, we1_a, lock0_a, lock1_a;
  logic [AW-1:0] addr0_a, addr1_a;
  logic [DW-1:0] wdata0_a, wdata1_a;
  logic          grant0_a, grant1_a, done0_a, done1_a;
  logic [DW-1:0] rdata_a;
  logic [AW-1:0] mem_address_a;
  logic [DW-1:0] mem_wdata_a;
  logic          mem_write_a;
  logic [DW-1:0] mem_rdata_a;
  logic [DW-1:0] mem_a [0:4095];

  spis_bus_arbiter #(.MEM_LATENCY(LAT_A), .MAX_BURST(4)) u_dut_a (
    .clock(clock), .resetN(resetN_a),
    .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
    .lock0(lock0_a), .lock1(lock1_a),
    .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
    .grant0(grant0_a), .grant1(grant1_a), .done0(done0_a), .done1(done1_a),
    .rdata(rdata_a), .memAddress(mem_address_a), .memWriteData(mem_wdata_a),
    .memWrite(mem_write_a), .memReadData(mem_rdata_a)
  );

  always @(posedge clock) begin
    if (mem_write_a) mem_a[mem_address_a] <= mem_wdata_a;
    mem_rdata_a <= mem_a[mem_address_a];
  end

  // ---------------- scoreboard state ----------------
  exp_t q0[$];
  exp_t q1[$];
  int   gq[$];          // expected order of grant rising edges (port index)
  int   done_log1[$];   // cycle numbers of done1 pulses
  int   wr_cycles = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_done(input int port);
    exp_t e;
    logic [DW-1:0] want;
    if ((port == 1 && q1.size() == 0) || (port == 0 && q0.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_unexpected_p%0d: done pulse with no expected access", port);
    end else begin
      e    = (port == 1) ? q1.pop_front() : q0.pop_front();
      want = e.is_wr ? model_rdata : e.rdata;
      check($sformatf("sb_rdata_p%0d", port), rdata, want);
      if (!e.is_wr) model_rdata = e.rdata;
    end
  endtask

  // Monitor: compares DUT outputs against the queues filled by the stimulus.
  initial begin
    logic g0_prev, g1_prev;
    int   want_port;
    g0_prev = 1'b0;
    g1_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (resetN === 1'b1) begin
        check("grant_onehot", grant0 & grant1, 0);
        if (mem_write) begin
          wr_cycles++;
          check("write_has_grant", grant0 ^ grant1, 1);
        end
        if ((grant0 && !g0_prev) || (grant1 && !g1_prev)) begin
          if (gq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_unexpected: grant rose (g0=%0b g1=%0b) with none expected", grant0, grant1);
          end else begin
            want_port = gq.pop_front();
            check("grant_order", grant1, want_port);
          end
        end
        if (done0) sb_done(0);
        if (done1) begin
          done_log1.push_back(cyc);
          sb_done(1);
        end
      end
      g0_prev = grant0;
      g1_prev = grant1;
    end
  end

  // ---------------- requester helpers (main instance) ----------------
  task automatic drop_req(input logic port);
    if (port) begin req1 = 1'b0; lock1 = 1'b0; end
    else      begin req0 = 1'b0; lock0 = 1'b0; end
  endtask

  task automatic wait_done(input logic port, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (t < 100 && !ok) begin
      @(negedge clock);
      t++;
      if ((port ? done1 : done0) === 1'b1) ok = 1'b1;
    end
    check($sformatf("done_seen_p%0d", port), ok, 1);
  endtask

  // n accesses; with lock the request drops after done n-1 because access n
  // has already been launched by then.
  task automatic run_access(input logic port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int n, input logic lk);
    bit ok;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; lock1 = lk; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; lock0 = lk; end
    for (int k = 0; k < n; k++) begin
      wait_done(port, ok);
      if (!ok) break;
      if (k == n - 2) drop_req(port);
    end
    drop_req(port);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, wr0, dones, got;
    bit ok;
    int exp_off[6];
    exp_off = '{3, 5, 7, 9, 14, 16};

    for (int i = 0; i < 4096; i++) begin
      mem[i]   = '0;
      mem_a[i] = '0;
    end
    mem[12'h123] = 8'h5A;
    mem[12'h040] = 8'h3C;
    mem_a[12'h000] = 8'hA5;

    resetN = 1'b0; resetN_a = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    req0_a = 0; req1_a = 0; we0_a = 0; we1_a = 0; lock0_a = 0; lock1_a = 0;
    addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;

    repeat (3) @(negedge clock);
    check("reset_ctrl", {grant0, grant1, done0, done1, mem_write}, 0);
    check("reset_bus", {mem_address, mem_wdata, rdata}, 0);
    check("reset_ctrl_a", {grant0_a, grant1_a, done0_a, done1_a, mem_write_a}, 0);
    resetN = 1'b1; resetN_a = 1'b1;
    @(negedge clock);

    // T1: single read from port 0, latency 1.
    q0.push_back('{1'b0, 8'h5A});
    gq.push_back(0);
    c = cyc; wr0 = wr_cycles;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
    @(negedge clock);
    check("t1_grant_c1", {grant0, grant1}, 2'b10);
    check("t1_mem_addr", mem_address, 12'h123);
    @(negedge clock);
    check("t1_no_early_done", done0, 0);
    @(negedge clock);
    check("t1_done0_c3", done0, 1);
    check("t1_rdata", rdata, 8'h5A);
    check("t1_latency", cyc - c, 3);
    req0 = 1'b0;
    check("t1_no_write", wr_cycles - wr0, 0);

    // T2: write from port 1 to the top address.
    q1.push_back('{1'b1, 8'h00});
    gq.push_back(1);
    wr0 = wr_cycles;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'hFFF; wdata1 = 8'hC3;
    @(negedge clock);
    check("t2_write_strobe", mem_write, 1);
    check("t2_write_addr", mem_address, 12'hFFF);
    check("t2_write_data", mem_wdata, 8'hC3);
    @(negedge clock);
    check("t2_strobe_one_cycle", mem_write, 0);
    @(negedge clock);
    check("t2_done1", done1, 1);
    check("t2_rdata_kept", rdata, 8'h5A);
    req1 = 1'b0; we1 = 1'b0;
    check("t2_write_cycles", wr_cycles - wr0, 1);
    check("t2_mem_written", mem[12'hFFF], 8'hC3);

    // T3: simultaneous requests, round-robin 0,1,0,1.
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    q0.push_back('{1'b0, 8'h5A}); q0.push_back('{1'b0, 8'h5A});
    q1.push_back('{1'b0, 8'hC3}); q1.push_back('{1'b0, 8'hC3});
    fork
      begin
        run_access(1'b0, 1'b0, 12'h123, 8'h00, 1, 1'b0);
        run_access(1'b0, 1'b0, 12'h123, 8'h00, 1, 1'b0);
      end
      begin
        run_access(1'b1, 1'b0, 12'hFFF, 8'h00, 1, 1'b0);
        run_access(1'b1, 1'b0, 12'hFFF, 8'h00, 1, 1'b0);
      end
    join

    // T4: port 1 locked burst of 6 with port 0 waiting, MAX_BURST=4.
    gq.push_back(1); gq.push_back(0); gq.push_back(1);
    for (int i = 0; i < 6; i++) q1.push_back('{1'b0, 8'h3C});
    q0.push_back('{1'b0, 8'h5A});
    done_log1.delete();
    c = cyc;
    fork
      run_access(1'b1, 1'b0, 12'h040, 8'h00, 6, 1'b1);
      begin
        @(negedge clock);
        run_access(1'b0, 1'b0, 12'h123, 8'h00, 1, 1'b0);
      end
    join
    check("t4_done1_count", done_log1.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < done_log1.size()) check($sformatf("t4_done1_cycle%0d", i), done_log1[i] - c, exp_off[i]);
    end

    check("sb_q0_drained", q0.size(), 0);
    check("sb_q1_drained", q1.size(), 0);
    check("sb_grants_drained", gq.size(), 0);

    // T5: reset asserted during WAIT on the long-latency instance.
    req0_a = 1'b1; we0_a = 1'b1; addr0_a = 12'h010; wdata0_a = 8'h77;
    @(negedge clock);
    check("t5_access_strobe", {grant0_a, mem_write_a}, 2'b11);
    @(negedge clock);
    @(negedge clock);
    check("t5_in_wait", {grant0_a, mem_write_a}, 2'b10);
    #2 resetN_a = 1'b0;
    #1;
    check("t5_async_ctrl", {grant0_a, grant1_a, done0_a, done1_a, mem_write_a}, 0);
    check("t5_async_addr", mem_address_a, 0);
    req0_a = 1'b0; we0_a = 1'b0;
    repeat (2) @(negedge clock);
    resetN_a = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clock);
      if (done0_a || done1_a) dones++;
    end
    check("t5_no_done_after_abort", dones, 0);

    // T6: read with MEM_LATENCY=15, done 17 cycles after sampling.
    c = cyc;
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 12'h000;
    @(negedge clock);
    check("t6_grant_c1", {grant0_a, grant1_a}, 2'b10);
    ok = 1'b0; got = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clock);
      if (done0_a === 1'b1) begin
        ok  = 1'b1;
        got = cyc - c;
      end
    end
    req0_a = 1'b0;
    check("t6_done_seen", ok, 1);
    check("t6_latency", got, LAT_A + 2);
    check("t6_rdata", rdata_a, 8'hA5);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
